// File: rtl/inst_mem_if.sv
// inst_mem_if: bus between the IF stage / program loader and the instruction
// memory.
//
// Signals
//   read_address : word address from the PC (16 bits)
//   inst         : instruction word at read_address (DATA_W bits)
//   prog_we      : programming write enable
//   prog_addr    : programming word address (16 bits)
//   prog_data    : programming write data (DATA_W bits)
//
// Handshake: there is no valid/ready pair. The read side is a pure
// combinational lookup. A programming write is a single-cycle strobe: every
// rising clk edge that sees prog_we=1 performs one write, and there is no
// back-pressure.
//
// Modports
//   master : PC / loader side, drives addresses and write data
//   slave  : memory side, returns inst
interface inst_mem_if #(
    parameter int DATA_W = 16
);
    logic [15:0]       read_address;
    logic [DATA_W-1:0] inst;
    logic              prog_we;
    logic [15:0]       prog_addr;
    logic [DATA_W-1:0] prog_data;

    modport master (
        output read_address,
        output prog_we,
        output prog_addr,
        output prog_data,
        input  inst
    );

    modport slave (
        input  read_address,
        input  prog_we,
        input  prog_addr,
        input  prog_data,
        output inst
    );
endinterface

// File: rtl/inst_mem.sv
// inst_mem: instruction memory for the 16-bit pipelined MIPS core.
//
// The memory holds a fixed boot image at power-up. A synchronous active-low
// reset reloads that image. The read path is purely combinational, so inst
// follows read_address with zero latency, even while no clock is running.
// Reads whose address lies outside the implemented depth return 0, which is
// the NOP encoding. The programming port writes one word per rising clk
// edge. Writes outside the implemented depth are dropped and do not alias
// onto lower words.
//
// Ports
//   clk   : single clock; writes and reset act on its rising edge
//   rst_n : synchronous active-low reset; restores the boot image
//   bus   : inst_mem_if.slave (read_address/inst, prog_we/prog_addr/prog_data)
module inst_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input logic          clk,
    input logic          rst_n,
    inst_mem_if.slave    bus
);
    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    // Boot program. Words 0-7 hold the image; every other word is a NOP.
    localparam mem_t BOOT = '{
        0:       DATA_W'(16'h2101),
        1:       DATA_W'(16'h2202),
        2:       DATA_W'(16'h0312),
        3:       DATA_W'(16'h4403),
        4:       DATA_W'(16'h5504),
        5:       DATA_W'(16'h6605),
        6:       DATA_W'(16'h7706),
        7:       DATA_W'(16'hE000),
        default: '0
    };

    // Depth expressed at address width so that the range checks compare
    // equal widths. The full address is compared against the depth, which
    // is what prevents out-of-range addresses from aliasing onto lower words.
    localparam logic [15:0] DEPTH_A = 16'(DEPTH);

    // The declaration initialiser provides the power-up contents.
    mem_t mem = BOOT;

    logic rd_in_range;
    logic wr_in_range;

    assign rd_in_range = (bus.read_address < DEPTH_A);
    assign wr_in_range = (bus.prog_addr    < DEPTH_A);

    // Reset takes priority over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem <= BOOT;
        end else if (bus.prog_we && wr_in_range) begin
            mem[bus.prog_addr[AW-1:0]] <= bus.prog_data;
        end
    end

    // Zero-latency read. Out-of-range addresses return the NOP encoding.
    always_comb begin
        bus.inst = '0;
        if (rd_in_range) begin
            bus.inst = mem[bus.read_address[AW-1:0]];
        end
    end
endmodule

// File: tb/tb_inst_mem.sv
// tb_inst_mem: directed self-checking bench for inst_mem.
//
// The stimulus runs as one linear sequence in a single initial block. Inputs
// change on the falling clock edge. The bench samples inst #1 after an input
// change, or #1 after the rising edge. Every expected value is a
// hand-computed constant.
module tb_inst_mem;
    logic clk;
    logic rst_n;

    int checks;
    int errors;

    inst_mem_if #(.DATA_W(16)) bus ();

    inst_mem #(
        .DATA_W(16),
        .DEPTH (256),
        .AW    (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // Clock / reset block. Reset starts deasserted so that the power-up
    // contents are observed without any reset edge.
    initial begin
        clk   = 1'b0;
        rst_n = 1'b1;
    end
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply a read address, let it settle, then compare inst.
    task automatic read_check(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        bus.read_address = addr;
        #1;
        check(tag, bus.inst, exp);
    endtask

    // One programming write. It is set up on a falling edge, takes effect on
    // the next rising edge, and is removed #1 afterwards.
    task automatic prog_write(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        @(posedge clk);
        #1;
        bus.prog_we = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.read_address = 16'h0000;
        bus.prog_we      = 1'b0;
        bus.prog_addr    = 16'h0000;
        bus.prog_data    = 16'h0000;

        // Power-up contents, read combinationally.
        read_check("pwr_w0", 16'd0, 16'h2101);
        #100;
        read_check("pwr_w7", 16'd7, 16'hE000);
        read_check("pwr_w8", 16'd8, 16'h0000);
        read_check("pwr_w3", 16'd3, 16'h4403);

        // Out-of-range reads return the NOP encoding.
        read_check("oor_0100", 16'h0100, 16'h0000);
        read_check("oor_ffff", 16'hFFFF, 16'h0000);

        // Programming: the old word is visible before the edge and the new
        // word after it.
        @(negedge clk);
        bus.prog_we      = 1'b1;
        bus.prog_addr    = 16'd5;
        bus.prog_data    = 16'hABCD;
        bus.read_address = 16'd5;
        #1;
        check("rdw_before", bus.inst, 16'h6605);
        @(posedge clk);
        #1;
        check("rdw_after", bus.inst, 16'hABCD);
        bus.prog_we = 1'b0;
        read_check("neighbour_w4", 16'd4, 16'h5504);

        // Top word is writable.
        prog_write(16'd255, 16'h1111);
        read_check("top_w255", 16'd255, 16'h1111);

        // A write to 256 is dropped; it must not alias onto word 0.
        prog_write(16'd256, 16'h9999);
        read_check("noalias_w0", 16'd0, 16'h2101);
        read_check("oor_w256", 16'd256, 16'h0000);
        read_check("w255_kept", 16'd255, 16'h1111);

        // A one-edge reset pulse restores the boot image.
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        read_check("rst_w5", 16'd5, 16'h6605);
        read_check("rst_w255", 16'd255, 16'h0000);
        read_check("rst_w0", 16'd0, 16'h2101);

        // Reset wins over a write on the same edge.
        @(negedge clk);
        rst_n            = 1'b0;
        bus.prog_we      = 1'b1;
        bus.prog_addr    = 16'd2;
        bus.prog_data    = 16'hBEEF;
        bus.read_address = 16'd2;
        @(posedge clk);
        #1;
        check("rst_prio_w2", bus.inst, 16'h0312);

        // Reset held for a second edge with a write to another word; the
        // write is also ignored.
        @(negedge clk);
        bus.prog_addr = 16'd9;
        bus.prog_data = 16'h5A5A;
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        bus.prog_we = 1'b0;
        read_check("rst_hold_w9", 16'd9, 16'h0000);
        read_check("rst_hold_w2", 16'd2, 16'h0312);

        // Writes work again after reset is released.
        prog_write(16'd9, 16'h1234);
        read_check("post_rst_w9", 16'd9, 16'h1234);
        read_check("post_rst_w6", 16'd6, 16'h7706);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
